// File: rtl/slice_write_sequencer.sv
// -----------------------------------------------------------------------------
// slice_write_sequencer
//
// Upstream command stage for the slice-update register. Slice-write requests
// (start offset, fill data, beat count) are accepted over a valid/ready
// handshake into a small FIFO. Each request is expanded into one single-cycle
// slice write per beat, and the offset advances by SLICE after every beat.
// The wr_* outputs connect directly to the downstream register's ctrl/din
// inputs. That register's sel input is tied to 1.
//
// Optional feature macro:
//   SLICE_SEQ_WRAP_EN - when defined, the beat offset wraps modulo WIDTH.
//                       When undefined, a beat at or past WIDTH is dropped
//                       with an err pulse and the burst ends.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous, active-high reset
//   req_valid   in   1      request present
//   req_ready   out  1      FIFO can accept (not full)
//   req_offset  in   OFFW   first-beat bit offset
//   req_data    in   SLICE  data written on every beat of the request
//   req_len     in   LENW   beats minus one
//   wr_en       out  1      slice write this cycle (registered)
//   wr_offset   out  OFFW   slice LSB position (registered, holds)
//   wr_data     out  SLICE  slice data (registered, holds)
//   err         out  1      one-cycle pulse: beat dropped as out of range
//   busy        out  1      burst in progress or FIFO non-empty
// -----------------------------------------------------------------------------
module slice_write_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int DEPTH = 4,
  parameter int LENW  = 3,
  parameter int OFFW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OFFW-1:0]  req_offset,
  input  logic [SLICE-1:0] req_data,
  input  logic [LENW-1:0]  req_len,
  output logic             wr_en,
  output logic [OFFW-1:0]  wr_offset,
  output logic [SLICE-1:0] wr_data,
  output logic             err,
  output logic             busy
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = PTRW + 1;
  // Two extra bits: the working offset can already sit at WIDTH (unwrapped)
  // and a further SLICE must still compare correctly against WIDTH.
  localparam int SUMW = OFFW + 2;

  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [PTRW-1:0] PTR_ONE   = {{(PTRW-1){1'b0}}, 1'b1};
  localparam logic [SUMW-1:0] WIDTH_S   = SUMW'(WIDTH);
  localparam logic [SUMW-1:0] SLICE_S   = SUMW'(SLICE);
  localparam logic [OFFW:0]   WIDTH_O   = (OFFW + 1)'(WIDTH);
  localparam logic [LENW-1:0] LEN_ZERO  = {LENW{1'b0}};
  localparam logic [LENW-1:0] LEN_ONE   = {{(LENW-1){1'b0}}, 1'b1};

  // ST_LAST: the beat on the outputs is the final one of its burst.
  // ST_MORE: the working registers hold the next beat of the current burst.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LAST = 2'd1,
    ST_MORE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [OFFW-1:0]  off_mem_q  [DEPTH];
  logic [SLICE-1:0] data_mem_q [DEPTH];
  logic [LENW-1:0]  len_mem_q  [DEPTH];

  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic fifo_full_s;
  logic fifo_empty_s;
  logic push_s;
  logic pop_s;

  // ---------------------------------------------------------------------------
  // Sequencer state, working burst registers and registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [OFFW:0]    off_q, off_d;
  logic [SLICE-1:0] data_q, data_d;
  logic [LENW-1:0]  rem_q, rem_d;

  logic             wr_en_q, wr_en_d;
  logic [OFFW-1:0]  wr_offset_q, wr_offset_d;
  logic [SLICE-1:0] wr_data_q, wr_data_d;
  logic             err_q, err_d;

  // Beat source for this edge: the working registers mid-burst, or the FIFO head
  logic             src_valid_s;
  logic [OFFW:0]    src_off_s;
  logic [SLICE-1:0] src_data_s;
  logic [LENW-1:0]  src_rem_s;
  logic [SUMW-1:0]  sum_s;
  logic             in_range_s;
  logic             last_s;
  logic [OFFW:0]    next_off_s;

  // FIFO status flags and handshake
  always_comb begin
    fifo_full_s  = (count_q == DEPTH_C);
    fifo_empty_s = (count_q == CNT_ZERO);
    req_ready    = !fifo_full_s;
    push_s       = req_valid && !fifo_full_s;
    // A new request is needed whenever no burst beats are pending.
    pop_s        = (state_q != ST_MORE) && !fifo_empty_s;
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Beat source selection and range evaluation
  always_comb begin
    src_valid_s = 1'b0;
    src_off_s   = off_q;
    src_data_s  = data_q;
    src_rem_s   = rem_q;
    if (state_q == ST_MORE) begin
      src_valid_s = 1'b1;
      src_off_s   = off_q;
      src_data_s  = data_q;
      src_rem_s   = rem_q;
    end else if (!fifo_empty_s) begin
      src_valid_s = 1'b1;
      src_off_s   = {1'b0, off_mem_q[rptr_q]};
      src_data_s  = data_mem_q[rptr_q];
      src_rem_s   = len_mem_q[rptr_q];
    end else begin
      src_valid_s = 1'b0;
      src_off_s   = off_q;
      src_data_s  = data_q;
      src_rem_s   = rem_q;
    end

    sum_s      = {1'b0, src_off_s} + SLICE_S;
    in_range_s = (sum_s <= WIDTH_S);
    // A dropped beat abandons the rest of its burst.
    last_s     = !in_range_s || (src_rem_s == LEN_ZERO);

`ifdef SLICE_SEQ_WRAP_EN
    if (sum_s >= WIDTH_S) begin
      next_off_s = sum_s[OFFW:0] - WIDTH_O;
    end else begin
      next_off_s = sum_s[OFFW:0];
    end
`else
    next_off_s = sum_s[OFFW:0];
`endif
  end

  // FSM next-state, working registers and output register next values
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    data_d      = data_q;
    rem_d       = rem_q;
    wr_en_d     = 1'b0;
    wr_offset_d = wr_offset_q;
    wr_data_d   = wr_data_q;
    err_d       = 1'b0;

    if (src_valid_s) begin
      wr_en_d = in_range_s;
      err_d   = !in_range_s;
      if (in_range_s) begin
        wr_offset_d = src_off_s[OFFW-1:0];
        wr_data_d   = src_data_s;
      end else begin
        wr_offset_d = wr_offset_q;
        wr_data_d   = wr_data_q;
      end
      if (last_s) begin
        // The next request (if any) is popped on the following edge, which is
        // also that request's first beat, so bursts chain without a bubble.
        state_d = ST_LAST;
        off_d   = off_q;
        data_d  = data_q;
        rem_d   = rem_q;
      end else begin
        state_d = ST_MORE;
        off_d   = next_off_s;
        data_d  = src_data_s;
        rem_d   = src_rem_s - LEN_ONE;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  // FIFO storage write (no reset needed: entries are qualified by count)
  always_ff @(posedge clk) begin
    if (push_s) begin
      off_mem_q[wptr_q]  <= req_offset;
      data_mem_q[wptr_q] <= req_data;
      len_mem_q[wptr_q]  <= req_len;
    end
  end

  // State, pointers, working registers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= {PTRW{1'b0}};
      rptr_q      <= {PTRW{1'b0}};
      count_q     <= CNT_ZERO;
      state_q     <= ST_IDLE;
      off_q       <= {(OFFW + 1){1'b0}};
      data_q      <= {SLICE{1'b0}};
      rem_q       <= LEN_ZERO;
      wr_en_q     <= 1'b0;
      wr_offset_q <= {OFFW{1'b0}};
      wr_data_q   <= {SLICE{1'b0}};
      err_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      off_q       <= off_d;
      data_q      <= data_d;
      rem_q       <= rem_d;
      wr_en_q     <= wr_en_d;
      wr_offset_q <= wr_offset_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
    end
  end

  // Output drive
  always_comb begin
    wr_en     = wr_en_q;
    wr_offset = wr_offset_q;
    wr_data   = wr_data_q;
    err       = err_q;
    busy      = (state_q != ST_IDLE) || !fifo_empty_s;
  end

endmodule

// File: tb/tb_slice_write_sequencer.sv
// Directed, table-driven bench for slice_write_sequencer (WIDTH=32, SLICE=8,
// DEPTH=4, LENW=3). Each table row is one clock cycle: inputs applied for that
// cycle and the outputs expected during that same cycle.
module tb_slice_write_sequencer;

`ifdef SLICE_SEQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_offset;
  logic [7:0] req_data;
  logic [2:0] req_len;
  logic       wr_en;
  logic [4:0] wr_offset;
  logic [7:0] wr_data;
  logic       err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  slice_write_sequencer #(
    .WIDTH(32), .SLICE(8), .DEPTH(4), .LENW(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_offset(req_offset),
    .req_data  (req_data),
    .req_len   (req_len),
    .wr_en     (wr_en),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [4:0] off;
    logic [7:0] data;
    logic [2:0] len;
    logic       rdy;
    logic       wen;
    logic [4:0] woff;
    logic [7:0] wdata;
    logic       err;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [4:0] o,
                     input logic [7:0] d, input logic [2:0] l,
                     input logic e_rdy, input logic e_wen, input logic [4:0] e_woff,
                     input logic [7:0] e_wd, input logic e_err, input logic e_busy);
    vec_t t;
    t.rst = r; t.vld = v; t.off = o; t.data = d; t.len = l;
    t.rdy = e_rdy; t.wen = e_wen; t.woff = e_woff; t.wdata = e_wd;
    t.err = e_err; t.busy = e_busy;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  // FIFO-full sequence data
  logic [4:0] rq_off [6];
  logic [7:0] rq_dat [6];
  logic [2:0] rq_len [6];
  int         exp_off[$];
  int         exp_dat[$];

  initial begin : main
    int acc;
    int nwr;
    int nerr;
    int a_end;
    logic [4:0] ov;

    ov = WRAP ? 5'd0 : 5'd24;

    // rst vld off   data   len  rdy wen woff   wdata  err            busy
    add(1, 0, 5'd0,  8'h00, 0,   1,  0,  5'd0,  8'h00, 0,             0); // reset state
    add(0, 1, 5'd8,  8'hAB, 0,   1,  0,  5'd0,  8'h00, 0,             0); // single beat
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  5'd0,  8'h00, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd8,  8'hAB, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  5'd8,  8'hAB, 0,             0);
    add(0, 1, 5'd0,  8'h5C, 3,   1,  0,  5'd8,  8'hAB, 0,             0); // 4-beat burst
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  5'd8,  8'hAB, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd0,  8'h5C, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd8,  8'h5C, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd16, 8'h5C, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd24, 8'h5C, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  5'd24, 8'h5C, 0,             0);
    add(0, 1, 5'd0,  8'h11, 1,   1,  0,  5'd24, 8'h5C, 0,             0); // back-to-back A
    add(0, 1, 5'd16, 8'h22, 0,   1,  0,  5'd24, 8'h5C, 0,             1); // back-to-back B
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd0,  8'h11, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd8,  8'h11, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd16, 8'h22, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  5'd16, 8'h22, 0,             0);
    add(0, 1, 5'd24, 8'h33, 1,   1,  0,  5'd16, 8'h22, 0,             0); // overflow burst
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  5'd16, 8'h22, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  1,  5'd24, 8'h33, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  WRAP, ov,  8'h33, !WRAP,         1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  ov,    8'h33, 0,             0);
    add(0, 1, 5'd28, 8'h44, 0,   1,  0,  ov,    8'h33, 0,             0); // misaligned
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  ov,    8'h33, 0,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  ov,    8'h33, 1,             1);
    add(0, 0, 5'd0,  8'h00, 0,   1,  0,  ov,    8'h33, 0,             0);

    rst = 1'b1; req_valid = 1'b0; req_offset = 5'd0; req_data = 8'h00; req_len = 3'd0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst        = vecs[i].rst;
      req_valid  = vecs[i].vld;
      req_offset = vecs[i].off;
      req_data   = vecs[i].data;
      req_len    = vecs[i].len;
      chk("req_ready", i, {31'd0, req_ready}, {31'd0, vecs[i].rdy});
      chk("wr_en",     i, {31'd0, wr_en},     {31'd0, vecs[i].wen});
      chk("wr_offset", i, {27'd0, wr_offset}, {27'd0, vecs[i].woff});
      chk("wr_data",   i, {24'd0, wr_data},   {24'd0, vecs[i].wdata});
      chk("err",       i, {31'd0, err},       {31'd0, vecs[i].err});
      chk("busy",      i, {31'd0, busy},      {31'd0, vecs[i].busy});
    end

    // ---------------- FIFO full: long burst then continuous requests --------
    rq_off = '{5'd0, 5'd0, 5'd8, 5'd16, 5'd24, 5'd0};
    rq_dat = '{8'h77, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hF6};
    rq_len = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < (WRAP ? 8 : 4); i++) begin
      exp_off.push_back(8 * (i % 4));
      exp_dat.push_back(32'h77);
    end
    for (int i = 1; i < 6; i++) begin
      exp_off.push_back(int'(rq_off[i]));
      exp_dat.push_back(int'(rq_dat[i]));
    end
    // Last cycle in which the FIFO is still full (until B is popped).
    a_end = WRAP ? 9 : 6;
    acc = 0; nwr = 0; nerr = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (wr_en) begin
        if (nwr < exp_off.size()) begin
          chk("full_woff", nwr, {27'd0, wr_offset}, exp_off[nwr]);
          chk("full_wdata", nwr, {24'd0, wr_data}, exp_dat[nwr]);
        end
        nwr++;
      end
      if (err) nerr++;
      if (cyc <= a_end + 1) begin
        chk("full_rdy", cyc, {31'd0, req_ready}, (cyc >= 5 && cyc <= a_end) ? 32'd0 : 32'd1);
      end
      if (acc < 6) begin
        req_valid  = 1'b1;
        req_offset = rq_off[acc];
        req_data   = rq_dat[acc];
        req_len    = rq_len[acc];
        if (req_ready) acc++;
      end else begin
        req_valid = 1'b0;
      end
    end
    chk("full_writes", 0, nwr, exp_off.size());
    chk("full_errs", 0, nerr, WRAP ? 32'd0 : 32'd1);
    chk("full_accepts", 0, acc, 32'd6);
    chk("full_busy_end", 0, {31'd0, busy}, 32'd0);

    // ---------------- Reset mid-burst with two queued entries ---------------
    @(negedge clk);
    req_valid = 1'b1; req_offset = 5'd0;  req_data = 8'h55; req_len = 3'd3;
    @(negedge clk);
    req_valid = 1'b1; req_offset = 5'd8;  req_data = 8'h66; req_len = 3'd0;
    @(negedge clk);
    req_valid = 1'b1; req_offset = 5'd16; req_data = 8'h67; req_len = 3'd0;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    chk("rstmid_pre_wen",  0, {31'd0, wr_en},     32'd1);
    chk("rstmid_pre_woff", 0, {27'd0, wr_offset}, 32'd8);
    chk("rstmid_pre_wd",   0, {24'd0, wr_data},   32'h55);
    chk("rstmid_pre_busy", 0, {31'd0, busy},      32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_wen",  0, {31'd0, wr_en},     32'd0);
    chk("rstmid_busy", 0, {31'd0, busy},      32'd0);
    chk("rstmid_rdy",  0, {31'd0, req_ready}, 32'd1);
    chk("rstmid_err",  0, {31'd0, err},       32'd0);
    chk("rstmid_woff", 0, {27'd0, wr_offset}, 32'd0);
    chk("rstmid_wd",   0, {24'd0, wr_data},   32'd0);
    nwr = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (wr_en || err) nwr++;
    end
    chk("rstmid_no_writes", 0, nwr, 32'd0);
    chk("rstmid_busy_end", 0, {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
